// File: rtl/bit_serial_pkg.sv
// Shared types for the bit-serial add controller.
// Holds the FSM state encoding and the supported width limit.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/bit_serial_add_ctrl_fa.sv
// Single full-adder logic cell, reused every cycle by the serial adder.
// Purely combinational: A, B, CI in; S, CO out.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walked LSB first over WIDTH bits.
// Optional subtract mode (sub_in, ovf) under macro BIT_SERIAL_SUB_EN.
module bit_serial_add_ctrl
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co_out,
    output logic             busy
`ifdef BIT_SERIAL_SUB_EN
    ,
    input  logic             sub_in,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_co;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_ci_eff;

`ifdef BIT_SERIAL_SUB_EN
    logic             r_ovf;

    // Subtract is A + ~B + 1, folded into the operand latch
    assign w_b_eff  = sub_in ? ~b_in : b_in;
    assign w_ci_eff = sub_in ? 1'b1 : ci_in;
    assign ovf      = r_ovf;
`else
    assign w_b_eff  = b_in;
    assign w_ci_eff = ci_in;
`endif

    full_adder u_fa (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // FSM, bit counter, operand/result shift registers and carry loop
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_co        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef BIT_SERIAL_SUB_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a_in;
                        r_b        <= w_b_eff;
                        r_carry    <= w_ci_eff;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    if (r_cnt == LAST) begin
                        r_co        <= w_co;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
`ifdef BIT_SERIAL_SUB_EN
                        r_ovf       <= r_carry ^ w_co;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign co_out    = r_co;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl (WIDTH=16).
// Directed cases plus 1000 random ops against an arithmetic model.
module tb_bit_serial_add_ctrl;

    localparam int W = 16;

    logic         QCK;
    logic         QRT;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ci_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co_out;
    logic         busy;
    bit           t_sub;
`ifdef BIT_SERIAL_SUB_EN
    logic         sub_in;
    logic         ovf;
    assign sub_in = t_sub;
`endif

    int n_tests;
    int n_fail;
    bit rnd_mode;

    bit           in_flight;
    int           age;
    logic [W-1:0] exp_sum;
    logic         exp_co;
    logic         exp_ovf;
    logic [W-1:0] last_sum;
    logic         last_co;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .QCK       (QCK),
        .QRT       (QRT),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .ci_in     (ci_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co_out    (co_out),
        .busy      (busy)
`ifdef BIT_SERIAL_SUB_EN
        ,
        .sub_in    (sub_in),
        .ovf       (ovf)
`endif
    );

    initial begin
        QCK = 1'b0;
        forever #5 QCK = ~QCK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Model: one op in flight, result = A + B + CI (or A + ~B + 1)
    always @(negedge QCK) begin
        if (QRT) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_co", co_out, 0);
            chk("rst_busy", busy, 0);
`ifdef BIT_SERIAL_SUB_EN
            chk("rst_ovf", ovf, 0);
`endif
            in_flight = 0;
            age = 0;
            last_sum = '0;
            last_co = 1'b0;
        end else begin
            chk("in_ready", in_ready, !in_flight);
            chk("busy", busy, in_flight && age < W);
            chk("out_valid", out_valid, in_flight && age >= W);
            if (in_flight && age >= W) begin
                chk("sum", sum, exp_sum);
                chk("co_out", co_out, exp_co);
`ifdef BIT_SERIAL_SUB_EN
                chk("ovf", ovf, exp_ovf);
`endif
            end else begin
                chk("co_hold", co_out, last_co);
                if (!in_flight || age == 0)
                    chk("sum_hold", sum, last_sum);
            end
            if (in_flight) begin
                if (age >= W && out_ready) begin
                    in_flight = 0;
                    last_sum = exp_sum;
                    last_co = exp_co;
                end else begin
                    age++;
                end
            end else if (in_valid) begin
                logic [W-1:0] eb;
                int unsigned  t;
                eb = t_sub ? ~b_in : b_in;
                t = int'(a_in) + int'(eb) + ((t_sub || ci_in) ? 1 : 0);
                exp_sum = t[W-1:0];
                exp_co = t[W];
                exp_ovf = (a_in[W-1] == eb[W-1]) && (exp_sum[W-1] != a_in[W-1]);
                in_flight = 1;
                age = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input bit sb);
        int k;
        @(posedge QCK);
        #1;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        ci_in = ci;
        t_sub = sb;
        k = 0;
        while (1) begin
            @(negedge QCK);
            if (in_ready) break;
            k++;
            if (k > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge QCK);
        #1;
        in_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (1) begin
            @(negedge QCK);
            n++;
            if (out_valid) break;
            if (n > 200) begin
                chk("result_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge QCK);
            #1;
            if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        int n;
        n_tests = 0;
        n_fail = 0;
        rnd_mode = 0;
        QRT = 1'b1;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        ci_in = 1'b0;
        t_sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge QCK);
        #1;
        QRT = 1'b0;
        @(negedge QCK);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_valid", out_valid, 0);
        chk("init_sum", sum, 0);

        // T1: plain add and accept-to-valid latency
        out_ready = 1'b1;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result(n);
        chk("T1_latency", n, 17);
        chk("T1_sum", sum, 16'h5555);
        chk("T1_co", co_out, 0);

        // T2: full carry ripple, via B and via CI
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result(n);
        chk("T2a_sum", sum, 16'h0000);
        chk("T2a_co", co_out, 1);
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_result(n);
        chk("T2b_sum", sum, 16'h0000);
        chk("T2b_co", co_out, 1);

        // T3: sink stall in DONE
        @(posedge QCK);
        #1;
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0F0F, 1'b1, 1'b0);
        wait_result(n);
        for (int i = 0; i < 5; i++) begin
            @(negedge QCK);
            chk("T3_valid", out_valid, 1);
            chk("T3_sum", sum, 16'h100F);
            chk("T3_co", co_out, 0);
            chk("T3_in_ready", in_ready, 0);
        end
        @(posedge QCK);
        #1;
        out_ready = 1'b1;
        @(negedge QCK);
        @(negedge QCK);
        chk("T3_idle_ready", in_ready, 1);
        chk("T3_idle_valid", out_valid, 0);

        // T4: reset while serialising bit 7
        issue(16'h00AA, 16'h0055, 1'b0, 1'b0);
        repeat (7) @(posedge QCK);
        #1;
        QRT = 1'b1;
        @(posedge QCK);
        #1;
        QRT = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge QCK);
            chk("T4_no_valid", out_valid, 0);
        end
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result(n);
        chk("T4_sum", sum, 16'h0002);
        chk("T4_co", co_out, 0);

`ifdef BIT_SERIAL_SUB_EN
        // T5: subtract mode
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_result(n);
        chk("T5a_sum", sum, 16'hFFFE);
        chk("T5a_co", co_out, 0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_result(n);
        chk("T5b_sum", sum, 16'h7FFF);
        chk("T5b_ovf", ovf, 1);
`endif

        // T6: random ops with random source and sink gaps
        rnd_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            bit sb;
`ifdef BIT_SERIAL_SUB_EN
            sb = $urandom_range(0, 1) == 1;
`else
            sb = 1'b0;
`endif
            repeat ($urandom_range(0, 3)) @(posedge QCK);
            issue(W'($urandom), W'($urandom), 1'($urandom), sb);
        end
        rnd_mode = 0;
        @(posedge QCK);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (in_flight && n < 100) begin
            @(negedge QCK);
            n++;
        end
        chk("T6_drain", in_flight, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
